// File: rtl/fir_pkg.sv
// Shared types, default sizing and the tap-count clamp for the FIR control path.
package fir_pkg;

    localparam int FIR_N_TAPS   = 16;
    localparam int FIR_ADDR_W   = 4;
    localparam int FIR_PIPE_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MAC,
        DRAIN,
        ZAPIS,
        DONE
    } fir_stan_t;

    // A zero tap count still computes one tap; anything above the memory depth is cut back to it.
    function automatic int fir_clamp_taps(input int ile, input int n_max);
        if (ile < 1) begin
            return 1;
        end
        if (ile > n_max) begin
            return n_max;
        end
        return ile;
    endfunction

endpackage

// File: rtl/fir_en_delay.sv
// Shift register that aligns the tap-issue strobe with the product arriving at the accumulator.
module fir_en_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk_b,
    input  logic rst_n,
    input  logic issue,
    output logic acc_en
);

    logic [DEPTH-1:0] stage_reg;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk_b or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= issue;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk_b or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= {stage_reg[DEPTH-2:0], issue};
                end
            end
        end
    endgenerate

    assign acc_en = stage_reg[DEPTH-1];

endmodule

// File: rtl/fir_ctrl_fsm.sv
// Sequences one FIR output per accepted sample: buffer write, per-tap address issue,
// accumulator clear/enable/transfer and a completion pulse.
module fir_ctrl_fsm
    import fir_pkg::*;
#(
    parameter int N_TAPS   = FIR_N_TAPS,
    parameter int ADDR_W   = FIR_ADDR_W,
    parameter int PIPE_LAT = FIR_PIPE_LAT
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   ile_taps,
    output logic              FSM_zapis_probki,
    output logic [ADDR_W-1:0] adr_probki,
    output logic [ADDR_W-1:0] adr_wsp,
    output logic              FSM_reset_Acc,
    output logic              FSM_Acc_en,
    output logic              FSM_Acc_zapis,
    output logic              busy,
    output logic              done,
    output logic              blad_przepelnienia
);

    localparam int TAPS_W = ADDR_W + 1;

    fir_stan_t         state_reg;
    logic [TAPS_W-1:0] k_reg;
    logic [TAPS_W-1:0] taps_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic              issue;

    // Every MAC cycle launches exactly one memory read / multiply.
    assign issue = (state_reg == MAC);

    fir_en_delay #(
        .DEPTH (PIPE_LAT)
    ) u_en_delay (
        .clk_b  (clk_b),
        .rst_n  (rst_n),
        .issue  (issue),
        .acc_en (FSM_Acc_en)
    );

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            k_reg              <= '0;
            taps_reg           <= '0;
            wr_ptr_reg         <= '0;
            FSM_zapis_probki   <= 1'b0;
            adr_probki         <= '0;
            adr_wsp            <= '0;
            FSM_reset_Acc      <= 1'b0;
            FSM_Acc_zapis      <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            blad_przepelnienia <= 1'b0;
        end else begin
            FSM_zapis_probki <= 1'b0;
            FSM_reset_Acc    <= 1'b0;
            FSM_Acc_zapis    <= 1'b0;
            done             <= 1'b0;
            adr_probki       <= '0;
            adr_wsp          <= '0;

            if (start && (state_reg != IDLE)) begin
                blad_przepelnienia <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        taps_reg         <= TAPS_W'(fir_clamp_taps(int'(ile_taps), N_TAPS));
                        state_reg        <= CLR;
                        busy             <= 1'b1;
                        FSM_reset_Acc    <= 1'b1;
                        FSM_zapis_probki <= 1'b1;
                        adr_probki       <= wr_ptr_reg;
                    end
                end
                CLR: begin
                    state_reg  <= MAC;
                    k_reg      <= '0;
                    adr_probki <= wr_ptr_reg;
                end
                MAC: begin
                    if (k_reg == taps_reg - TAPS_W'(1)) begin
                        state_reg <= DRAIN;
                        k_reg     <= '0;
                    end else begin
                        // Newest sample pairs with coefficient 0; older samples wrap below address 0.
                        k_reg      <= k_reg + TAPS_W'(1);
                        adr_wsp    <= ADDR_W'(k_reg + TAPS_W'(1));
                        adr_probki <= wr_ptr_reg - ADDR_W'(k_reg + TAPS_W'(1));
                    end
                end
                DRAIN: begin
                    if (k_reg == TAPS_W'(PIPE_LAT - 1)) begin
                        state_reg     <= ZAPIS;
                        k_reg         <= '0;
                        FSM_Acc_zapis <= 1'b1;
                    end else begin
                        k_reg <= k_reg + TAPS_W'(1);
                    end
                end
                ZAPIS: begin
                    state_reg <= DONE;
                    done      <= 1'b1;
                end
                DONE: begin
                    state_reg  <= IDLE;
                    busy       <= 1'b0;
                    wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ctrl_fsm.sv
// Randomised self-checking bench: expected control timeline from closed-form run timing,
// FIR result from a direct convolution over the sample history.
module tb_fir_ctrl_fsm;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int L  = 2;

    logic          clk_b = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   ile_taps = '0;
    logic          FSM_zapis_probki;
    logic [AW-1:0] adr_probki;
    logic [AW-1:0] adr_wsp;
    logic          FSM_reset_Acc;
    logic          FSM_Acc_en;
    logic          FSM_Acc_zapis;
    logic          busy;
    logic          done;
    logic          blad_przepelnienia;

    fir_ctrl_fsm #(
        .N_TAPS   (N),
        .ADDR_W   (AW),
        .PIPE_LAT (L)
    ) dut (
        .clk_b              (clk_b),
        .rst_n              (rst_n),
        .start              (start),
        .ile_taps           (ile_taps),
        .FSM_zapis_probki   (FSM_zapis_probki),
        .adr_probki         (adr_probki),
        .adr_wsp            (adr_wsp),
        .FSM_reset_Acc      (FSM_reset_Acc),
        .FSM_Acc_en         (FSM_Acc_en),
        .FSM_Acc_zapis      (FSM_Acc_zapis),
        .busy               (busy),
        .done               (done),
        .blad_przepelnienia (blad_przepelnienia)
    );

    always #5 clk_b = ~clk_b;

    int n_checks = 0;
    int n_pass   = 0;
    int wp       = 0;
    int done_cnt = 0;
    int last_en_cnt = 0;
    int last_result = 0;
    bit blad_exp = 1'b0;
    int coef [N];
    int smem [1 << AW];
    int hist [$];
    int prod_hist [64];

    // One complete run starting in the current cycle; inject>0 pulses start again at that cycle.
    task automatic run_fir(input int ile, input int sample, input int inject);
        int taps, t_done, acc, result, en_cnt, expv, n;
        logic [5:0] exp_ctrl, obs_ctrl;
        logic [7:0] exp_adr, obs_adr;
        taps   = (ile < 1) ? 1 : ((ile > N) ? N : ile);
        t_done = taps + 3 + L;
        acc    = 0;
        result = -1;
        en_cnt = 0;
        hist.push_back(sample);
        n    = hist.size() - 1;
        expv = 0;
        for (int k = 0; k < taps; k++) begin
            if (n - k >= 0) expv += coef[k] * hist[n - k];
        end
        for (int c = 0; c <= t_done; c++) begin
            @(posedge clk_b);
            #1;
            start    = (c == 0) || (c == inject);
            ile_taps = 5'(ile);
            @(negedge clk_b);
            exp_ctrl = {c == 1, c == 1, (c >= 2 + L) && (c <= taps + 1 + L),
                        c == taps + 2 + L, c == t_done, (c >= 1) && (c <= t_done)};
            obs_ctrl = {FSM_reset_Acc, FSM_zapis_probki, FSM_Acc_en, FSM_Acc_zapis, done, busy};
            if (c == 1) exp_adr = {4'(wp), 4'(0)};
            else if (c >= 2 && c <= taps + 1) exp_adr = {4'(wp - (c - 2)), 4'(c - 2)};
            else exp_adr = 8'h00;
            obs_adr = {adr_probki, adr_wsp};
            n_checks++;
            if (obs_ctrl !== exp_ctrl)
                $display("FAIL ctrl taps=%0d cycle=%0d got=%b want=%b", taps, c, obs_ctrl, exp_ctrl);
            else n_pass++;
            n_checks++;
            if (obs_adr !== exp_adr)
                $display("FAIL addr taps=%0d cycle=%0d got=%h want=%h", taps, c, obs_adr, exp_adr);
            else n_pass++;
            n_checks++;
            if (blad_przepelnienia !== blad_exp)
                $display("FAIL blad cycle=%0d got=%b want=%b", c, blad_przepelnienia, blad_exp);
            else n_pass++;
            if (FSM_zapis_probki) smem[adr_probki] = sample;
            prod_hist[c] = smem[adr_probki] * coef[adr_wsp];
            if (FSM_reset_Acc) acc = 0;
            if (FSM_Acc_en) begin
                en_cnt++;
                if (c >= L) acc += prod_hist[c - L];
            end
            if (FSM_Acc_zapis) result = acc;
            if (done) done_cnt++;
            if (c >= 1 && start) blad_exp = 1'b1;
        end
        n_checks++;
        if (result !== expv)
            $display("FAIL fir_result taps=%0d got=%0d want=%0d", taps, result, expv);
        else n_pass++;
        $display("run taps=%0d wr_ptr=%0d sample=%0d result=%0d en=%0d", taps, wp, sample, result, en_cnt);
        wp = (wp + 1) % (1 << AW);
        last_en_cnt = en_cnt;
        last_result = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk_b);
        n_checks++;
        if ({FSM_zapis_probki, adr_probki, adr_wsp, FSM_reset_Acc, FSM_Acc_en,
             FSM_Acc_zapis, busy, done, blad_przepelnienia} !== 15'd0)
            $display("FAIL reset_outputs got=%b want=0", {FSM_zapis_probki, adr_probki, adr_wsp,
                     FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, busy, done, blad_przepelnienia});
        else n_pass++;
        $display("reset outputs checked");
        @(posedge clk_b);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int samples [4];
        samples = '{10, 20, 30, 40};
        for (int i = 0; i < N; i++) coef[i] = (i < 4) ? i + 1 : 0;
        for (int i = 0; i < 4; i++) run_fir(4, samples[i], -1);
        n_checks++;
        if (last_result !== 200) $display("FIR FAIL basic_fir4 got=%0d want=200", last_result);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int dc0;
        dc0 = done_cnt;
        for (int i = 0; i < N; i++) coef[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 17; i++) run_fir(16, int'($urandom_range(0, 255)), -1);
        n_checks++;
        if (done_cnt - dc0 !== 17) $display("FAIL wrap_done_count got=%0d want=17", done_cnt - dc0);
        else n_pass++;
    endtask

    task automatic test_clamp();
        run_fir(0, int'($urandom_range(0, 255)), -1);
        n_checks++;
        if (last_en_cnt !== 1) $display("FAIL clamp_low_en got=%0d want=1", last_en_cnt);
        else n_pass++;
        run_fir(20, int'($urandom_range(0, 255)), -1);
        n_checks++;
        if (last_en_cnt !== 16) $display("FAIL clamp_high_en got=%0d want=16", last_en_cnt);
        else n_pass++;
    endtask

    task automatic test_overflow();
        run_fir(4, int'($urandom_range(0, 255)), 5);
        run_fir(4, int'($urandom_range(0, 255)), 4 + 3 + L);
        run_fir(4, int'($urandom_range(0, 255)), -1);
        n_checks++;
        if (blad_przepelnienia !== 1'b1) $display("FAIL overflow_sticky got=%b want=1", blad_przepelnienia);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        @(posedge clk_b);
        #1 start = 1'b1;
        ile_taps = 5'd4;
        @(posedge clk_b);
        #1 start = 1'b0;
        repeat (3) @(posedge clk_b);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({FSM_zapis_probki, adr_probki, adr_wsp, FSM_reset_Acc, FSM_Acc_en,
             FSM_Acc_zapis, busy, done, blad_przepelnienia} !== 15'd0)
            $display("FAIL async_reset got=%b want=0", {FSM_zapis_probki, adr_probki, adr_wsp,
                     FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, busy, done, blad_przepelnienia});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_b);
            n_checks++;
            if ({FSM_Acc_zapis, done, busy} !== 3'b000)
                $display("FAIL reset_hold cycle=%0d got=%b want=000", i, {FSM_Acc_zapis, done, busy});
            else n_pass++;
        end
        $display("mid-run reset checked");
        @(posedge clk_b);
        #1 rst_n = 1'b1;
        wp = 0;
        blad_exp = 1'b0;
        hist.delete();
        for (int i = 0; i < (1 << AW); i++) smem[i] = 0;
        run_fir(4, int'($urandom_range(0, 255)), -1);
    endtask

    task automatic test_random();
        int ile, taps, inj;
        for (int i = 0; i < N; i++) coef[i] = int'($urandom_range(0, 255));
        for (int r = 0; r < 20; r++) begin
            ile  = int'($urandom_range(0, 20));
            taps = (ile < 1) ? 1 : ((ile > N) ? N : ile);
            inj  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, taps + 3 + L)) : -1;
            run_fir(ile, int'($urandom_range(0, 255)), inj);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) smem[i] = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_overflow();
        test_mid_reset();
        test_random();
        @(posedge clk_b);
        #1 start = 1'b0;
        repeat (3) @(negedge clk_b);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL final_idle got=%b want=00", {busy, done});
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_ctrl_fsm.md
Name: fir_ctrl_fsm

Overview:
- Control FSM that sequences one FIR output computation per accepted input sample.
- Writes the new sample into the circular sample buffer.
- Issues sample and coefficient read addresses, one tap per cycle.
- Drives the accumulator's FSM_reset_Acc, FSM_Acc_en and FSM_Acc_zapis, timed against the multiply pipeline latency, and signals completion with a done pulse.

Parameters:
- N_TAPS, 16: maximum tap count; also the coefficient memory depth.
- ADDR_W, 4: sample/coefficient address width; 2**ADDR_W must be >= N_TAPS.
- PIPE_LAT, 2: cycles from address issue to the product being valid at suma_wynik (memory read + registered multiply); legal range 1..4.

Ports:
- clk_b, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: new-sample pulse; accepted only in IDLE.
- ile_taps, in, ADDR_W+1: runtime tap count, latched on an accepted start.
- FSM_zapis_probki, out, 1: sample-buffer write strobe.
- adr_probki, out, ADDR_W: sample-buffer address (write or read).
- adr_wsp, out, ADDR_W: coefficient-memory read address.
- FSM_reset_Acc, out, 1: clear accumulator.
- FSM_Acc_en, out, 1: accumulate the current suma_wynik.
- FSM_Acc_zapis, out, 1: transfer accumulator to FIR_probka_wynik.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse; FIR_probka_wynik is valid.
- blad_przepelnienia, out, 1: sticky flag; a start arrived while busy.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; wr_ptr=0; tap counter 0; enable delay line cleared. Reset mid-run abandons the run with no zapis and no done. Internal state is restored on release.
- Tap count: taps = clamp(ile_taps, 1, N_TAPS), latched on an accepted start.
- IDLE: start=1 -> CLR. Otherwise hold.
- CLR, 1 cycle: FSM_reset_Acc=1, FSM_zapis_probki=1, adr_probki=wr_ptr -> MAC with k=0.
- MAC, taps cycles:
  - adr_wsp=k.
  - adr_probki=(wr_ptr-k) mod 2**ADDR_W, wrapping below 0.
  - issue=1.
  - k increments each cycle. At k=taps-1 -> DRAIN.
- Enable timing: FSM_Acc_en is issue delayed by exactly PIPE_LAT cycles through the delay line. It is never asserted in the same cycle as FSM_reset_Acc.
- DRAIN, PIPE_LAT cycles: no issue; the delay line empties -> ZAPIS.
- ZAPIS, 1 cycle: FSM_Acc_zapis=1 -> DONE.
- DONE, 1 cycle: done=1; wr_ptr <= wr_ptr+1, mod 2**ADDR_W -> IDLE.
- Run timing: with start sampled at cycle 0:
  - CLR at cycle 1.
  - MAC at cycles 2..taps+1.
  - FSM_Acc_en at cycles 2+PIPE_LAT..taps+1+PIPE_LAT.
  - ZAPIS at taps+2+PIPE_LAT.
  - done at taps+3+PIPE_LAT.
  - Back-to-back starts are accepted every taps+4+PIPE_LAT cycles.
- start while busy: ignored and the run is unaffected; blad_przepelnienia <= 1, cleared only by reset.
- start in the DONE cycle: ignored and flagged. Acceptance is IDLE-only.
- Outputs are registered or decoded from the state register. Addresses are 0 outside CLR/MAC.

Decomposition:
- Package fir_pkg:
  - state enum fir_stan_t {IDLE, CLR, MAC, DRAIN, ZAPIS, DONE}.
  - Constants FIR_N_TAPS, FIR_ADDR_W, FIR_PIPE_LAT.
  - Clamp function for the tap count.
- Sub-module fir_en_delay: PIPE_LAT-deep shift register for issue -> FSM_Acc_en, with asynchronous clear.
- The FSM, tap counter and wr_ptr stay in the top module.

Test Plan:
- Reset, then start with ile_taps=4, PIPE_LAT=2:
  - FSM_reset_Acc at cycle 1.
  - adr_wsp 0,1,2,3 at cycles 2-5 and adr_probki 0,15,14,13.
  - FSM_Acc_en at cycles 4-7, FSM_Acc_zapis at 8, done at 9.
  - wr_ptr is 1 afterwards.
- With the accumulator and memory model, coefficients {1,2,3,4} and samples 10,20,30,40 fed over 4 runs: 4th FIR_probka_wynik = 40*1+30*2+20*3+10*4 = 200.
- 17 consecutive runs with ile_taps=16: write address wraps 15 -> 0; read addresses wrap correctly; done count is 17.
- ile_taps=0 behaves as 1 (one FSM_Acc_en pulse). ile_taps=20 behaves as 16 (16 pulses).
- start pulsed at cycle 5 of a run: no change to address or enable sequence; blad_przepelnienia=1 and stays 1 through later runs.
- rst_n low at cycle 4 mid-MAC: all outputs 0 asynchronously; no zapis and no done. The next start after release gives the standard timing from wr_ptr=0.
